// File: rtl/riscv_core_mul_seq.sv
// Sequential integer multiplier for the RISC-V M extension.
// Radix-2^DIGIT_BITS modified Booth: one Booth digit of the multiplier is
// retired per cycle into a right-shifting accumulator. Handles MUL, MULH,
// MULHSU and MULHU, plus MULW with early termination on RV64.
module riscv_core_mul_seq #(
  parameter int XLEN       = 64,
  parameter int DIGIT_BITS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mul_valid,
  output logic            o_mul_ready,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  input  logic [1:0]      i_mul_control,
  input  logic            i_mul_isword,
  input  logic            i_mul_flush,
  output logic            o_mul_valid,
  input  logic            i_mul_ready,
  output logic [XLEN-1:0] o_mul_result
);

  // Widths: operands carry two extra bits so every signedness combination is
  // a plain signed*signed product.
  localparam int K         = DIGIT_BITS;
  localparam int AW        = XLEN + 2;
  localparam int ITER_FULL = (XLEN + 2 + K - 1) / K;
  localparam int ITER_WORD = (XLEN / 2 + 2 + K - 1) / K;
  localparam int LW        = K * ITER_FULL;          // product bits shifted out
  localparam int MW        = LW + 1;                 // multiplier plus Booth guard bit
  localparam int HW        = AW + K + 1;             // running high partial sum
  localparam int CW        = $clog2(ITER_FULL + 1);
  localparam int NMUL      = (1 << (K - 1)) + 1;     // multiples 0 .. 2^(K-1)
  localparam int WOFF      = LW - K * ITER_WORD;     // where a MULW product lands

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [CW-1:0]   last_q,   last_d;
  logic [AW-1:0]   mcand_q,  mcand_d;
  logic [MW-1:0]   mult_q,   mult_d;
  logic [HW-1:0]   hi_q,     hi_d;
  logic [LW-1:0]   lo_q,     lo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            isword_q, isword_d;
  logic [1:0]      ctl_q,    ctl_d;

  // Operand capture values
  logic            ld_isword;
  logic [1:0]      ld_ctl;
  logic            ld_a_signed;
  logic            ld_b_signed;
  logic [AW-1:0]   ld_mcand;
  logic [AW-1:0]   ld_mplier;
  logic [CW-1:0]   ld_last;

  // Booth step signals
  logic [K:0]      win;
  logic [K:0]      digit;
  logic            neg;
  logic [K:0]      mag;
  logic [HW-1:0]   mcand_ext;
  logic [HW-1:0]   pp_mag;
  logic [HW-1:0]   pp;
  logic [HW-1:0]   acc_sum;
  logic [HW-1:0]   step_hi;
  logic [LW-1:0]   step_lo;
  logic [MW-1:0]   step_mult;
  logic [HW+LW-1:0] prod_cat;
  logic [XLEN-1:0] final_res;

  logic            accept;
  logic            unused_bits;

  // Extend operands according to the requested signedness; MULW folds to a
  // signed 32x32 product regardless of the control field.
  always_comb begin
    ld_isword   = (XLEN == 64) && i_mul_isword;
    ld_ctl      = ld_isword ? 2'b00 : i_mul_control;
    ld_a_signed = (ld_ctl != 2'b11);
    ld_b_signed = !ld_ctl[1];
    if (ld_isword) begin
      ld_mcand  = AW'($signed(i_mul_srcA[31:0]));
      ld_mplier = AW'($signed(i_mul_srcB[31:0]));
      ld_last   = CW'(ITER_WORD - 1);
    end else begin
      ld_mcand  = {{2{ld_a_signed & i_mul_srcA[XLEN-1]}}, i_mul_srcA};
      ld_mplier = {{2{ld_b_signed & i_mul_srcB[XLEN-1]}}, i_mul_srcB};
      ld_last   = CW'(ITER_FULL - 1);
    end
  end

  // Booth digit from the low K+1 multiplier bits: signed(win[K:1]) + win[0]
  always_comb begin
    win   = mult_q[K:0];
    digit = {win[K], win[K:1]} + {{K{1'b0}}, win[0]};
    neg   = digit[K];
    mag   = neg ? -digit : digit;
  end

  assign mcand_ext = HW'($signed(mcand_q));

  // Multiple table built by shift/add (even = double a smaller one, odd = add
  // the multiplicand once more), with a one-hot pick chained alongside.
  genvar gi;
  generate
    for (gi = 0; gi < NMUL; gi++) begin : g_mult
      logic [HW-1:0] m;
      logic [HW-1:0] pick;
      if (gi == 0) begin : g_zero
        assign m    = '0;
        assign pick = '0;
      end else begin : g_nz
        if (gi % 2 == 1) begin : g_odd
          assign m = g_mult[gi-1].m + mcand_ext;
        end else begin : g_even
          assign m = {g_mult[gi/2].m[HW-2:0], 1'b0};
        end
        assign pick = g_mult[gi-1].pick | ((mag == (K+1)'(gi)) ? m : '0);
      end
    end
  endgenerate

  assign pp_mag = g_mult[NMUL-1].pick;

  // One accumulate-and-shift step; low bits retire into the lo register.
  always_comb begin
    pp        = neg ? -pp_mag : pp_mag;
    acc_sum   = hi_q + pp;
    step_hi   = {{K{acc_sum[HW-1]}}, acc_sum[HW-1:K]};
    step_lo   = {acc_sum[K-1:0], lo_q[LW-1:K]};
    step_mult = {{K{mult_q[MW-1]}}, mult_q[MW-1:K]};
    prod_cat  = {step_hi, step_lo};
    if (isword_q) begin
      final_res = XLEN'($signed(prod_cat[WOFF +: 32]));
    end else if (ctl_q == 2'b00) begin
      final_res = prod_cat[XLEN-1:0];
    end else begin
      final_res = prod_cat[2*XLEN-1:XLEN];
    end
  end

  assign unused_bits = ^{prod_cat, lo_q[K-1:0]};

  // Ready is combinational on the consumer's ready only while holding a result.
  always_comb begin
    case (state_q)
      S_IDLE:  o_mul_ready = 1'b1;
      S_DONE:  o_mul_ready = i_mul_ready;
      default: o_mul_ready = 1'b0;
    endcase
  end

  assign accept       = i_mul_valid && o_mul_ready && !i_mul_flush;
  assign o_mul_valid  = (state_q == S_DONE);
  assign o_mul_result = result_q;

  // Next-state: load on accept, iterate while busy, hold result until taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    mcand_d  = mcand_q;
    mult_d   = mult_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    isword_d = isword_q;
    ctl_d    = ctl_q;

    case (state_q)
      S_BUSY: begin
        hi_d   = step_hi;
        lo_d   = step_lo;
        mult_d = step_mult;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == last_q) begin
          state_d  = S_DONE;
          result_d = final_res;
        end
      end
      S_DONE: begin
        if (i_mul_ready) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = S_BUSY;
      cnt_d    = '0;
      last_d   = ld_last;
      mcand_d  = ld_mcand;
      mult_d   = {LW'($signed(ld_mplier)), 1'b0};
      hi_d     = '0;
      lo_d     = '0;
      isword_d = ld_isword;
      ctl_d    = ld_ctl;
    end

    // A kill drops whatever is in flight, including a result completing now.
    if (i_mul_flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State registers; reset wins over every other event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      mcand_q  <= '0;
      mult_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      isword_q <= 1'b0;
      ctl_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      mcand_q  <= mcand_d;
      mult_q   <= mult_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      isword_q <= isword_d;
      ctl_q    <= ctl_d;
    end
  end

endmodule

// File: doc/riscv_core_mul_seq.md
RISCV_CORE_MUL_SEQ -- requirements
Module: riscv_core_mul_seq

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter DIGIT_BITS, default 4, multiplier bits retired per cycle (radix-16 modified Booth); legal values 2 and 4.
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_mul_valid  in  1  request valid.
REQ-006 o_mul_ready  out  1  block can accept a request this cycle.
REQ-007 i_mul_srcA  in  XLEN  multiplicand (rs1).
REQ-008 i_mul_srcB  in  XLEN  multiplier (rs2).
REQ-009 i_mul_control  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 i_mul_isword  in  1  MULW; ignored when XLEN=32.
REQ-011 i_mul_flush  in  1  abort in-flight operation (pipeline kill).
REQ-012 o_mul_valid  out  1  result valid.
REQ-013 i_mul_ready  in  1  consumer accepts result.
REQ-014 o_mul_result  out  XLEN  result.

Function
REQ-015 Request accepted on a rising edge where i_mul_valid && o_mul_ready && !i_mul_flush; srcA, srcB, control, isword captured at that edge; inputs are don't-care afterwards.
REQ-016 States: IDLE, BUSY, DONE.
REQ-017 IDLE: o_mul_ready=1, o_mul_valid=0; on accept -> BUSY.
REQ-018 BUSY: o_mul_ready=0; one Booth digit accumulated per cycle; ITER = ceil((XLEN+2)/DIGIT_BITS) cycles, reduced to ceil((XLEN/2+2)/DIGIT_BITS) when isword (early termination); after last iteration -> DONE.
REQ-019 Latency: o_mul_valid rises exactly ITER edges after the accept edge (XLEN=64, DIGIT_BITS=4: 17 for full-width ops, 9 for MULW).
REQ-020 DONE: o_mul_valid=1, o_mul_result stable until handshake; o_mul_ready = i_mul_ready.
REQ-021 DONE with i_mul_ready=1 and i_mul_valid=0 -> IDLE; with i_mul_valid=1 -> result retired and new request accepted on the same edge -> BUSY (back-to-back).
REQ-022 DONE with i_mul_ready=0 -> remain in DONE indefinitely; no request accepted.
REQ-023 Operands extended to XLEN+2 bits: srcA sign-extended for MUL/MULH/MULHSU, zero-extended for MULHU; srcB sign-extended for MUL/MULH, zero-extended for MULHSU/MULHU.
REQ-024 Result: MUL low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU high XLEN bits of signed*signed, signed*unsigned, unsigned*unsigned product respectively.
REQ-025 isword=1 (XLEN=64): signed product of srcA[31:0] and srcB[31:0], low 32 bits sign-extended to 64; control treated as 00 regardless of value.
REQ-026 Flush: i_mul_flush=1 at any edge forces IDLE, o_mul_valid=0 next cycle; pending result discarded; flush overrides a simultaneous accept and a simultaneous result handshake.
REQ-027 o_mul_result holds last value when o_mul_valid=0; consumers use it only when o_mul_valid=1.
REQ-028 No combinational path from i_mul_srcA/srcB to any output.

Reset
REQ-029 i_rst=1 at an edge: state IDLE, o_mul_valid=0, o_mul_result=0, iteration counter and accumulator cleared; overrides flush, accept and handshake.
REQ-030 Reset mid-BUSY or in DONE discards the operation; o_mul_ready=1 in first cycle after i_rst deasserts.

Verification
REQ-031 XLEN=64, MULH, srcA=srcB=0x8000_0000_0000_0000 -> o_mul_valid 17 cycles after accept, result 0x4000_0000_0000_0000; MUL same operands -> 0.
REQ-032 MULHU srcA=srcB=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU same operands -> 0xFFFF_FFFF_FFFF_FFFF; MUL -> 0x0000_0000_0000_0001.
REQ-033 isword=1, control=11, srcA=0x1234_5678_7FFF_FFFF, srcB=2 -> result 0xFFFF_FFFF_FFFF_FFFE after 9 cycles.
REQ-034 Hold i_mul_ready=0 for 5 cycles in DONE -> o_mul_valid and result stable, o_mul_ready=0; then i_mul_ready=1 with i_mul_valid=1 -> new op accepted same edge, next result 17 cycles later.
REQ-035 Assert i_mul_flush at cycle 8 of BUSY -> no o_mul_valid pulse, IDLE next cycle; repeat with i_rst instead -> same, result register reads 0.
REQ-036 2000 random requests, random control/isword, random i_mul_ready and valid gaps -> every result equals reference model for REQ-024/025; count of results equals count of accepts minus flushed.
